gonso_sequencer: RTL and testbench



---
 rtl/gonso_pkg.sv | 19 +
 rtl/gonso_seq_addr_gen.sv | 47 ++++
 rtl/gonso_sequencer.sv | 145 ++++++++++++++
 tb/tb_gonso_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gonso_pkg.sv
// gonso_pkg: shared types and constants for the gonso word sequencer.
// Memory geometry, FSM state encoding and word address type.
package gonso_pkg;

  localparam int GONSO_AW = 6;
  localparam int GONSO_DW = 8;

  typedef logic [GONSO_AW-1:0] word_addr_t;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CAP,
    WAIT,
    WR,
    FIN
  } state_t;

endpackage

// File: rtl/gonso_seq_addr_gen.sv
// gonso_seq_addr_gen: current word address and pass counter.
// Address walks first..last modulo 2^AW; last_word/last_pass flag the end.
module gonso_seq_addr_gen
  import gonso_pkg::*;
#(
  parameter int AW = GONSO_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          step,
  input  logic [AW-1:0] first,
  input  logic [AW-1:0] last,
  input  logic [3:0]    count,
  output logic [AW-1:0] cur_addr,
  output logic [AW-1:0] next_addr,
  output logic          last_word,
  output logic          last_pass
);

  logic [AW-1:0] first_q;
  logic [AW-1:0] last_q;
  logic [3:0]    pass;

  assign last_word = (cur_addr == last_q);
  assign last_pass = (pass <= 4'd1);
  assign next_addr = last_word ? first_q
                               : cur_addr + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      first_q  <= '0;
      last_q   <= '0;
      cur_addr <= '0;
      pass     <= '0;
    end else if (load) begin
      first_q  <= first;
      last_q   <= last;
      cur_addr <= first;
      pass     <= count;
    end else if (step && !(last_word && last_pass)) begin
      cur_addr <= next_addr;
      if (last_word) pass <= pass - 4'd1;
    end
  end

endmodule

// File: rtl/gonso_sequencer.sv
// gonso_sequencer: read / datapath / write-back passes over a word range.
// Optional abort input is enabled with `define GONSO_SEQ_ABORT_EN.
module gonso_sequencer
  import gonso_pkg::*;
#(
  parameter int AW     = GONSO_AW,
  parameter int DW     = GONSO_DW,
  parameter int DP_LAT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    w_count,
  input  logic [AW-1:0] w_first,
  input  logic [AW-1:0] w_last,
  input  logic          start,
`ifdef GONSO_SEQ_ABORT_EN
  input  logic          abort,
`endif
  output logic          progress,
  output logic          done,
  output logic          cs_n,
  output logic          we_n,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] wdata,
  input  logic [DW-1:0] rdata,
  output logic [DW-1:0] dp_in,
  output logic          dp_valid,
  input  logic [DW-1:0] dp_out
);

  state_t        state;
  logic [3:0]    lat_cnt;
  logic          kill;
  logic          go_fin;
  logic          ag_load;
  logic          ag_step;
  logic          last_word;
  logic          last_pass;
  logic [AW-1:0] cur_addr;
  logic [AW-1:0] next_addr;

`ifdef GONSO_SEQ_ABORT_EN
  assign kill = abort;
`else
  assign kill = 1'b0;
`endif

  assign ag_load = (state == IDLE) && start
                && (w_count != 4'd0);
  assign ag_step = (state == WR);

  gonso_seq_addr_gen #(
    .AW(AW)
  ) u_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ag_load),
    .step     (ag_step),
    .first    (w_first),
    .last     (w_last),
    .count    (w_count),
    .cur_addr (cur_addr),
    .next_addr(next_addr),
    .last_word(last_word),
    .last_pass(last_pass)
  );

  // Abort drops an unwritten word; a word already in WR completes.
  always_comb begin
    go_fin = 1'b0;
    unique case (state)
      RD, CAP, WAIT: go_fin = kill;
      WR:            go_fin = kill || (last_word && last_pass);
      default:       go_fin = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      lat_cnt  <= '0;
      progress <= 1'b0;
      done     <= 1'b0;
      cs_n     <= 1'b1;
      we_n     <= 1'b1;
      addr     <= '0;
      wdata    <= '0;
      dp_in    <= '0;
      dp_valid <= 1'b0;
    end else begin
      done     <= 1'b0;
      dp_valid <= 1'b0;
      if (go_fin) begin
        state    <= FIN;
        cs_n     <= 1'b1;
        we_n     <= 1'b1;
        progress <= 1'b0;
        done     <= 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            if (start && w_count != 4'd0) begin
              state    <= RD;
              progress <= 1'b1;
              cs_n     <= 1'b0;
              we_n     <= 1'b1;
              addr     <= w_first;
            end else if (start) begin
              done <= 1'b1;
            end
          end
          RD: begin
            state <= CAP;
            cs_n  <= 1'b1;
          end
          CAP: begin
            state    <= WAIT;
            dp_in    <= rdata;
            dp_valid <= 1'b1;
            lat_cnt  <= 4'(DP_LAT);
          end
          WAIT: begin
            lat_cnt <= lat_cnt - 4'd1;
            if (lat_cnt == 4'd1) begin
              state <= WR;
              wdata <= dp_out;
              cs_n  <= 1'b0;
              we_n  <= 1'b0;
              addr  <= cur_addr;
            end
          end
          WR: begin
            state <= RD;
            cs_n  <= 1'b0;
            we_n  <= 1'b1;
            addr  <= next_addr;
          end
          FIN: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gonso_sequencer.sv
// tb_gonso_sequencer: per-cycle schedule model plus memory/datapath models.
// Directed and random sequences; abort cases need GONSO_SEQ_ABORT_EN.
module tb_gonso_sequencer;

  localparam int L = 2;

  typedef struct {
    logic       prog;
    logic       done;
    logic       csn;
    logic       wen;
    logic       dpv;
    logic       ck_addr;
    logic [5:0] addr;
    logic       ck_wd;
    logic [7:0] wdata;
    logic       ck_dpin;
    logic [7:0] dpin;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] w_count;
  logic [5:0] w_first;
  logic [5:0] w_last;
  logic       start;
`ifdef GONSO_SEQ_ABORT_EN
  logic       abort;
`endif
  logic       progress;
  logic       done;
  logic       cs_n;
  logic       we_n;
  logic [5:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic [7:0] dp_in;
  logic       dp_valid;
  logic [7:0] dp_out;

  logic [7:0] mem [64];
  logic [7:0] model_mem [64];
  exp_t       exp_q [$];
  exp_t       ce;

  int n_tests;
  int n_fail;
  int cyc;
  int t_start;
  int done_cyc;
  int prog_cnt;
  logic chk_en;

  gonso_sequencer #(
    .AW(6),
    .DW(8),
    .DP_LAT(L)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .w_count (w_count),
    .w_first (w_first),
    .w_last  (w_last),
    .start   (start),
`ifdef GONSO_SEQ_ABORT_EN
    .abort   (abort),
`endif
    .progress(progress),
    .done    (done),
    .cs_n    (cs_n),
    .we_n    (we_n),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .dp_in   (dp_in),
    .dp_valid(dp_valid),
    .dp_out  (dp_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // datapath model: increment
  assign dp_out = dp_in + 8'd1;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // memory macro model
  initial begin
    rdata = 8'h00;
    for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
    mem[5] = 8'h12;
    forever begin
      @(posedge clk);
      if (cs_n === 1'b0) begin
        if (we_n) rdata <= mem[addr];
        else mem[addr] = wdata;
      end
    end
  end

  function automatic exp_t idle_rec();
    exp_t e;
    e.prog = 1'b0; e.done = 1'b0;
    e.csn = 1'b1; e.wen = 1'b1; e.dpv = 1'b0;
    e.ck_addr = 1'b0; e.addr = '0;
    e.ck_wd = 1'b0; e.wdata = '0;
    e.ck_dpin = 1'b0; e.dpin = '0;
    return e;
  endfunction

  always @(negedge clk) begin
    if (done === 1'b1) done_cyc = cyc;
    if (progress === 1'b1) prog_cnt++;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      ce = (exp_q.size() != 0) ? exp_q.pop_front() : idle_rec();
      n_tests++;
      if (progress !== ce.prog || done !== ce.done
          || cs_n !== ce.csn || we_n !== ce.wen
          || dp_valid !== ce.dpv
          || (ce.ck_addr && addr !== ce.addr)
          || (ce.ck_wd && wdata !== ce.wdata)
          || (ce.ck_dpin && dp_in !== ce.dpin)) begin
        n_fail++;
        $display("FAIL cycle %0d: got p%b d%b cs%b we%b dv%b a%0d wd%h di%h, want p%b d%b cs%b we%b dv%b a%0d(%b) wd%h(%b) di%h(%b)",
                 cyc, progress, done, cs_n, we_n, dp_valid, addr, wdata, dp_in,
                 ce.prog, ce.done, ce.csn, ce.wen, ce.dpv,
                 ce.addr, ce.ck_addr, ce.wdata, ce.ck_wd, ce.dpin, ce.ck_dpin);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic mem_ok(input string name);
    int bad;
    bad = -1;
    for (int i = 0; i < 64; i++)
      if (mem[i] !== model_mem[i]) bad = i;
    n_tests++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s: mem[%0d] got %h want %h",
               name, bad, mem[bad], model_mem[bad]);
    end
  endtask

  // mode: 0 plain, 1 reset at ev, 2 abort at ev, 3 start re-pulse at ev
  task automatic plan(input logic [5:0] f, input logic [5:0] l,
                      input logic [3:0] c, input int mode, input int ev);
    int n, per, tt, last_t, w, j;
    logic [5:0] a, span;
    exp_t e;
    span = l - f;
    n = int'(span) + 1;
    per = L + 3;
    tt = int'(c) * n * per + 1;
    last_t = (mode == 1 || mode == 2) ? ev : tt;
    for (int t = 1; t <= last_t; t++) begin
      e = idle_rec();
      if (t < tt) begin
        w = (t - 1) / per;
        j = (t - 1) % per;
        a = f + 6'(w % n);
        e.prog = 1'b1;
        if (j == 0) begin
          e.csn = 1'b0; e.ck_addr = 1'b1; e.addr = a;
        end
        if (j == 2) begin
          e.dpv = 1'b1; e.ck_dpin = 1'b1; e.dpin = model_mem[a];
        end
        if (j == per - 1) begin
          e.csn = 1'b0; e.wen = 1'b0;
          e.ck_addr = 1'b1; e.addr = a;
          e.ck_wd = 1'b1; e.wdata = model_mem[a] + 8'd1;
          model_mem[a] = model_mem[a] + 8'd1;
        end
      end else begin
        e.done = 1'b1;
      end
      exp_q.push_back(e);
    end
    if (mode == 1) begin
      e = idle_rec();
      e.ck_addr = 1'b1; e.ck_wd = 1'b1; e.ck_dpin = 1'b1;
      exp_q.push_back(e);
    end
    if (mode == 2) begin
      e = idle_rec();
      e.done = 1'b1;
      exp_q.push_back(e);
    end
  endtask

  task automatic run_seq(input logic [5:0] f, input logic [5:0] l,
                         input logic [3:0] c, input int mode, input int ev);
    int k;
    @(negedge clk);
    #1;
    w_first = f; w_last = l; w_count = c; start = 1'b1;
    t_start = cyc; done_cyc = -1; prog_cnt = 0;
    plan(f, l, c, mode, ev);
    @(negedge clk);
    #1;
    start = 1'b0;
    w_first = 6'($urandom); w_last = 6'($urandom);
    w_count = 4'($urandom);
    k = 1;
    while (k <= 6000 && (exp_q.size() != 0 || k <= ev)) begin
      if (k == ev) begin
        case (mode)
          1: rst_n = 1'b0;
`ifdef GONSO_SEQ_ABORT_EN
          2: abort = 1'b1;
`endif
          3: begin
            start = 1'b1; w_count = 4'hF;
            w_first = 6'($urandom); w_last = 6'($urandom);
          end
          default: ;
        endcase
      end
      @(negedge clk);
      #1;
      rst_n = 1'b1; start = 1'b0;
`ifdef GONSO_SEQ_ABORT_EN
      abort = 1'b0;
`endif
      k++;
    end
    if (exp_q.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL timeout: %0d expected cycles left", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  logic [7:0] p0, p1, p2, p3, p4, p62;

  initial begin
    rst_n = 1'b0; start = 1'b0;
    w_count = '0; w_first = '0; w_last = '0;
`ifdef GONSO_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    chk_en = 1'b0; n_tests = 0; n_fail = 0;
    done_cyc = -1; prog_cnt = 0; t_start = 0;
    repeat (3) @(negedge clk);
    chk("rst_ctl", {27'd0, progress, done, cs_n, we_n, dp_valid},
        32'b00110);
    chk("rst_addr", {26'd0, addr}, 32'd0);
    chk("rst_data", {16'd0, wdata, dp_in}, 32'd0);
    for (int i = 0; i < 64; i++) model_mem[i] = mem[i];
    #1;
    rst_n = 1'b1;
    chk_en = 1'b1;

    run_seq(6'd5, 6'd5, 4'd1, 0, 0);
    chk("one_lat", done_cyc - t_start, 6);
    chk("one_prog", prog_cnt, 5);
    chk("one_mem5", {24'd0, mem[5]}, 32'h13);
    mem_ok("one_mem");

    p2 = mem[2]; p3 = mem[3]; p4 = mem[4];
    run_seq(6'd2, 6'd4, 4'd2, 3, 3);
    chk("two_lat", done_cyc - t_start, 31);
    chk("two_prog", prog_cnt, 30);
    chk("two_mem", {8'd0, mem[2], mem[3], mem[4]},
        {8'd0, p2 + 8'd2, p3 + 8'd2, p4 + 8'd2});
    mem_ok("two_mem_all");

    p1 = mem[1]; p2 = mem[2]; p62 = mem[62];
    run_seq(6'd62, 6'd1, 4'd1, 0, 0);
    chk("wrap_lat", done_cyc - t_start, 21);
    chk("wrap_mem", {8'd0, mem[62], mem[1], mem[2]},
        {8'd0, p62 + 8'd1, p1 + 8'd1, p2});
    mem_ok("wrap_mem_all");

    run_seq(6'd9, 6'd20, 4'd0, 0, 0);
    chk("zero_lat", done_cyc - t_start, 1);
    chk("zero_prog", prog_cnt, 0);

    p2 = mem[2]; p3 = mem[3];
    run_seq(6'd0, 6'd7, 4'd1, 1, 18);
    chk("rst_nodone", done_cyc, 32'hFFFF_FFFF);
    chk("rst_mem", {16'd0, mem[2], mem[3]},
        {16'd0, p2 + 8'd1, p3});
    mem_ok("rst_mem_all");

`ifdef GONSO_SEQ_ABORT_EN
    p0 = mem[0];
    run_seq(6'd0, 6'd3, 4'd1, 2, 3);
    chk("abw_mem0", {24'd0, mem[0]}, {24'd0, p0});
    chk("abw_lat", done_cyc - t_start, 4);
    mem_ok("abw_mem_all");
    p0 = mem[0]; p1 = mem[1];
    run_seq(6'd0, 6'd3, 4'd1, 2, 5);
    chk("abr_mem", {16'd0, mem[0], mem[1]},
        {16'd0, p0 + 8'd1, p1});
    chk("abr_lat", done_cyc - t_start, 6);
    mem_ok("abr_mem_all");
`else
    p0 = 8'd0;
`endif

    for (int r = 0; r < 20; r++) begin
      logic [5:0] f;
      logic [3:0] c;
      int m;
      f = 6'($urandom);
      c = 4'($urandom_range(0, 3));
      m = (r % 4 == 3 && c != 4'd0) ? 3 : 0;
      run_seq(f, f + 6'($urandom_range(0, 6)), c, m,
              (m == 3) ? $urandom_range(1, 4) : 0);
      mem_ok("rand_mem");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
